// File: rtl/ariane_pkg.sv
// Shared frontend types for the branch history table: update/prediction
// records, the per-entry table record and the 2-bit counter step function.
// Purely declarative; no logic, no latency, no flow control.
package ariane_pkg;

  // Virtual address width of fetch and resolve PCs.
  localparam int unsigned VLEN = 64;

  // Resolved branch coming back from the backend.
  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic            taken;
  } bht_update_t;

  // Per-slot prediction handed to the fetch stage.
  typedef struct packed {
    logic valid;
    logic taken;
  } bht_prediction_t;

  // One table entry: 'valid' means trained at least once since the last clear.
  typedef struct packed {
    logic       valid;
    logic [1:0] saturation_counter;
  } bht_entry_t;

  // Cleared entry: untrained, weakly taken.
  localparam bht_entry_t BHT_ENTRY_RST = '{valid: 1'b0, saturation_counter: 2'b10};

  typedef enum logic {
    BHT_IDLE,
    BHT_FLUSH
  } bht_state_e;

  // 2-bit saturating counter step: up on taken, down on not-taken,
  // pinned at 2'b11 and 2'b00.
  function automatic logic [1:0] sat_cnt_upd(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != 2'b11) nxt = cnt + 2'd1;
    end else begin
      if (cnt != 2'b00) nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/gshare_bht_multi.sv
// Multi-slot gshare/bimodal branch history table with a row-by-row flush sweep.
// Latency: prediction is combinational from vpc_i; training is visible one cycle later.
// Backpressure: none; updates arriving during a sweep, in debug mode or with flush_i are dropped.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   flush_i            start a table sweep and clear the global history
//   debug_mode_i       blocks all training and history shifts (sweeps keep running)
//   vpc_i              fetch address; selects the row read for every slot
//   bht_update_i       resolved branch {valid, pc, taken}
//   update_ghr_i       history that was exported with the prediction of that branch
//   bht_prediction_o   {valid, taken} per fetch slot
//   pred_ghr_o         history used for this cycle's prediction
//   flush_busy_o       sweep in progress
module gshare_bht_multi
  import ariane_pkg::*;
#(
  parameter int unsigned NR_ENTRIES      = 1024,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned HIST_BITS       = 8,
  parameter bit          GSHARE_EN       = 1'b1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   flush_i,
  input  logic                                   debug_mode_i,
  input  logic            [VLEN-1:0]             vpc_i,
  input  bht_update_t                            bht_update_i,
  input  logic            [HIST_BITS-1:0]        update_ghr_i,
  output bht_prediction_t [INSTR_PER_FETCH-1:0]  bht_prediction_o,
  output logic            [HIST_BITS-1:0]        pred_ghr_o,
  output logic                                   flush_busy_o
);

  localparam int unsigned NR_ROWS  = NR_ENTRIES / INSTR_PER_FETCH;
  localparam int unsigned ROW_BITS = $clog2(NR_ROWS);
  // Bit 0 is the compressed-instruction halfword; the column bits sit above it.
  localparam int unsigned OFF      = $clog2(INSTR_PER_FETCH) + 1;
  localparam int unsigned COL_BITS = (INSTR_PER_FETCH > 1) ? $clog2(INSTR_PER_FETCH) : 1;

  // Row hash. History is zero-extended to the row width before the XOR, so
  // only the low HIST_BITS of the PC row field are perturbed.
  function automatic logic [ROW_BITS-1:0] row_idx(input logic [VLEN-1:0]      pc,
                                                   input logic [HIST_BITS-1:0] hist);
    logic [ROW_BITS-1:0] pc_row;
    pc_row = ROW_BITS'(pc >> OFF);
    return GSHARE_EN ? (pc_row ^ ROW_BITS'(hist)) : pc_row;
  endfunction

  function automatic logic [COL_BITS-1:0] col_idx(input logic [VLEN-1:0] pc);
    return (INSTR_PER_FETCH > 1) ? COL_BITS'(pc >> 1) : '0;
  endfunction

  bht_state_e          state_q;
  logic [ROW_BITS-1:0] sweep_q;
  logic [HIST_BITS-1:0] ghr_q;
  bht_entry_t          tbl_q [NR_ROWS][INSTR_PER_FETCH];

  // ---------------------------------------------------------------------------
  // Prediction path (combinational)
  // ---------------------------------------------------------------------------
  logic [ROW_BITS-1:0] pred_row;
  assign pred_row = row_idx(vpc_i, ghr_q);

  always_comb begin
    for (int i = 0; i < INSTR_PER_FETCH; i++) begin
      // Half-swept table contents must never reach fetch.
      bht_prediction_o[i].valid = tbl_q[pred_row][i].valid & (state_q == BHT_IDLE);
      bht_prediction_o[i].taken = tbl_q[pred_row][i].saturation_counter[1];
    end
  end

  assign pred_ghr_o   = ghr_q;
  assign flush_busy_o = (state_q == BHT_FLUSH);

  // ---------------------------------------------------------------------------
  // Update path
  // ---------------------------------------------------------------------------
  logic [ROW_BITS-1:0] upd_row;
  logic [COL_BITS-1:0] upd_col;
  logic                upd_en;
  bht_entry_t          upd_old;
  bht_entry_t          upd_new;

  // The update indexes with the history seen at predict time, so it trains
  // exactly the entry that produced the prediction.
  assign upd_row = row_idx(bht_update_i.pc, update_ghr_i);
  assign upd_col = col_idx(bht_update_i.pc);
  assign upd_old = tbl_q[upd_row][upd_col];
  assign upd_new = '{valid: 1'b1,
                     saturation_counter: sat_cnt_upd(upd_old.saturation_counter,
                                                      bht_update_i.taken)};

  assign upd_en = bht_update_i.valid & ~debug_mode_i & ~flush_i & (state_q == BHT_IDLE);

  // ---------------------------------------------------------------------------
  // FSM, sweep counter, history and the single table write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BHT_IDLE;
      sweep_q <= '0;
      ghr_q   <= '0;
      for (int r = 0; r < NR_ROWS; r++) begin
        for (int c = 0; c < INSTR_PER_FETCH; c++) begin
          tbl_q[r][c] <= BHT_ENTRY_RST;
        end
      end
    end else begin
      if (flush_i) begin
        // Also restarts a sweep already in progress from row 0.
        state_q <= BHT_FLUSH;
        sweep_q <= '0;
        ghr_q   <= '0;
      end else begin
        case (state_q)
          BHT_FLUSH: begin
            for (int c = 0; c < INSTR_PER_FETCH; c++) begin
              tbl_q[sweep_q][c] <= BHT_ENTRY_RST;
            end
            sweep_q <= sweep_q + ROW_BITS'(1);
            if (&sweep_q) state_q <= BHT_IDLE;
          end
          default: begin
            if (upd_en) begin
              tbl_q[upd_row][upd_col] <= upd_new;
              // Shift left, dropping the oldest outcome.
              ghr_q <= HIST_BITS'({ghr_q, bht_update_i.taken});
            end
          end
        endcase
      end
    end
  end

  // Only the row/column bit fields of the addresses are consumed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{vpc_i, bht_update_i.pc};

endmodule
